aes128_round_ctrl: RTL and testbench

AES128_ROUND_CTRL -- requirements
Module: aes128_round_ctrl

---
 rtl/aes128_pkg.sv | 19 +
 rtl/aes128_round_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 round controller.
//   state_e   : controller FSM states
//   NR_AES128 : number of rounds for a 128-bit key
//   RK_IDX_W  : width of round-key index and round number buses
package aes128_pkg;

  localparam int NR_AES128 = 10;
  localparam int RK_IDX_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITKEY,
    ST_INIT,
    ST_ROUND,
    ST_LAST,
    ST_OUT
  } state_e;

endpackage

// File: rtl/aes128_round_ctrl.sv
// AES-128 round sequencer. Steps the external datapath through the initial
// AddRoundKey, NR-1 full rounds and the final (MixColumns-bypassed) round,
// then holds the result valid until the downstream handshake.
// Ports:
//   i_Clk, i_Rst        : clock, synchronous active-high reset
//   i_Valid / o_Ready   : block offer / controller idle (accept handshake)
//   i_fDec              : mode of offered block, latched on accept -> o_fDec
//   i_KeyRdy            : key store holds a valid round-key set; low stalls
//   o_StateLd           : load input block into state register (accept cycle)
//   o_StateEn           : capture round result into state register
//   o_RkIdx, o_Round    : round-key index and current round number
//   o_fFirst            : AddRoundKey-only initial step
//   o_fMixBypass        : final round, MixColumns bypassed
//   o_Valid / i_Ready   : result valid / downstream accept
//   o_Busy              : any state other than idle
module aes128_round_ctrl
  import aes128_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic                i_fDec,
  input  logic                i_KeyRdy,
  output logic                o_StateLd,
  output logic                o_StateEn,
  output logic [RK_IDX_W-1:0] o_RkIdx,
  output logic [RK_IDX_W-1:0] o_Round,
  output logic                o_fFirst,
  output logic                o_fMixBypass,
  output logic                o_fDec,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic                o_Busy
);

  localparam logic [RK_IDX_W-1:0] NR_L = RK_IDX_W'(NR);

  state_e              state_reg, state_next;
  logic [RK_IDX_W-1:0] round_reg, round_next;
  logic                dec_reg, dec_next;
  logic                round_act;  // INIT/ROUND/LAST: round-key bus is live

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg <= ST_IDLE;
      round_reg <= '0;
      dec_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      dec_reg   <= dec_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    round_next   = round_reg;
    dec_next     = dec_reg;
    o_Ready      = 1'b0;
    o_Busy       = 1'b1;
    o_StateLd    = 1'b0;
    o_StateEn    = 1'b0;
    o_fFirst     = 1'b0;
    o_fMixBypass = 1'b0;
    o_Valid      = 1'b0;
    round_act    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        o_Ready = 1'b1;
        o_Busy  = 1'b0;
        if (i_Valid) begin
          o_StateLd  = 1'b1;
          dec_next   = i_fDec;
          round_next = '0;
          state_next = i_KeyRdy ? ST_INIT : ST_WAITKEY;
        end
      end

      ST_WAITKEY: begin
        if (i_KeyRdy) state_next = ST_INIT;
      end

      ST_INIT: begin
        round_act = 1'b1;
        o_fFirst  = 1'b1;
        if (i_KeyRdy) begin
          o_StateEn = 1'b1;
          // A single-round configuration skips straight to the final round.
          if (NR_L == RK_IDX_W'(1)) begin
            round_next = NR_L;
            state_next = ST_LAST;
          end else begin
            round_next = RK_IDX_W'(1);
            state_next = ST_ROUND;
          end
        end
      end

      ST_ROUND: begin
        round_act = 1'b1;
        if (i_KeyRdy) begin
          o_StateEn = 1'b1;
          // >= keeps the counter bounded by NR even if it were ever corrupted.
          if (round_reg >= NR_L - RK_IDX_W'(1)) begin
            round_next = NR_L;
            state_next = ST_LAST;
          end else begin
            round_next = round_reg + RK_IDX_W'(1);
          end
        end
      end

      ST_LAST: begin
        round_act    = 1'b1;
        o_fMixBypass = 1'b1;
        if (i_KeyRdy) begin
          o_StateEn  = 1'b1;
          round_next = '0;
          state_next = ST_OUT;
        end
      end

      ST_OUT: begin
        o_Valid = 1'b1;
        if (i_Ready) state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        round_next = '0;
      end
    endcase
  end

  // round_reg is 0 in INIT and NR in LAST, so one expression covers all
  // three active states; decrypt walks the key schedule backwards.
  assign o_Round = round_act ? round_reg : '0;
  assign o_RkIdx = round_act ? (dec_reg ? (NR_L - round_reg) : round_reg) : '0;
  assign o_fDec  = dec_reg;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
module tb_aes128_round_ctrl;
  import aes128_pkg::*;

  localparam int NR = NR_AES128;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_dec, key_rdy, in_ready;
  logic       out_ready, state_ld, state_en, first, bypass, out_dec, out_valid, busy;
  logic [3:0] rk_idx, round_num;

  aes128_round_ctrl #(.NR(NR)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Valid     (in_valid),
    .o_Ready     (out_ready),
    .i_fDec      (in_dec),
    .i_KeyRdy    (key_rdy),
    .o_StateLd   (state_ld),
    .o_StateEn   (state_en),
    .o_RkIdx     (rk_idx),
    .o_Round     (round_num),
    .o_fFirst    (first),
    .o_fMixBypass(bypass),
    .o_fDec      (out_dec),
    .o_Valid     (out_valid),
    .i_Ready     (in_ready),
    .o_Busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          done;
    logic [10:0] step;  // {rk, round, first, bypass, dec}
    int          cyc;   // cycle o_Valid must first rise (done records)
  } exp_t;
  exp_t sb[$];

  bit mon_en = 0;
  int ld_count = 0;
  bit valid_prev = 0;
  bit ready_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected DUT output (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expected round steps on every o_StateEn and the expected
  // completion cycle on each rising o_Valid.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (state_ld === 1'b1) ld_count <= ld_count + 1;
      if (state_en === 1'b1) begin
        if (sb.size() == 0) flag("unexpected_step");
        else begin
          e = sb.pop_front();
          if (e.done) flag("step_instead_of_valid");
          else chk("round_step", {rk_idx, round_num, first, bypass, out_dec}, e.step);
        end
      end
      if (out_valid === 1'b1 && !valid_prev) begin
        if (sb.size() == 0) flag("unexpected_valid");
        else begin
          e = sb.pop_front();
          if (!e.done) flag("valid_before_last_step");
          else chk("valid_latency", cyc, e.cyc);
        end
      end
      if (out_valid === 1'b1)
        chk("out_outputs_zero", {rk_idx, round_num, first, bypass, state_en}, 0);
      if (valid_prev) chk("valid_hold", out_valid, !ready_prev);
      valid_prev <= (out_valid === 1'b1);
      ready_prev <= (in_ready === 1'b1);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},  out_ready, 1);
    chk({tag, "_valid"},  out_valid, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_ld"},     state_ld, 0);
    chk({tag, "_en"},     state_en, 0);
    chk({tag, "_rk"},     rk_idx, 0);
    chk({tag, "_round"},  round_num, 0);
    chk({tag, "_first"},  first, 0);
    chk({tag, "_bypass"}, bypass, 0);
    chk({tag, "_dec"},    out_dec, 0);
  endtask

  task automatic idle(input int n);
    in_valid = 0; key_rdy = 1; in_ready = 1; in_dec = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one block from accept to handshake (or to an abort reset).
  // w: key-not-ready cycles at accept; s_round/s_len: key stall at a round;
  // r_delay: cycles i_Ready held low in OUT; noise: i_Valid held high and
  // i_fDec toggled after accept; abort_round: reset in that round (-1 none).
  task automatic run_block(input bit dec, input int w, input int s_round, input int s_len,
                           input int r_delay, input bit noise, input int abort_round);
    int t0, tout, k;
    logic [3:0] rk;
    exp_t e;
    t0 = cyc;
    for (int r = 0; r <= NR; r++) begin
      if (abort_round >= 0 && r > abort_round) break;
      rk = dec ? 4'(NR - r) : 4'(r);
      e.done = 0;
      e.step = {rk, 4'(r), (r == 0), (r == NR), dec};
      e.cyc = 0;
      sb.push_back(e);
    end
    tout = t0 + 12 + w + s_len;
    if (abort_round < 0) begin
      e.done = 1; e.step = '0; e.cyc = tout;
      sb.push_back(e);
    end
    $display("block: dec=%0d keywait=%0d stall@%0d x%0d ready_delay=%0d noise=%0d abort@%0d accept=%0d",
             dec, w, s_round, s_len, r_delay, noise, abort_round, t0);
    for (int c = t0; c <= tout + r_delay; c++) begin
      k = c - t0;
      in_valid = (k == 0) || noise;
      in_dec   = (k == 0) ? dec : ((noise && (k % 2 == 1)) ? ~dec : dec);
      key_rdy  = !(k < w) && !(s_len > 0 && k >= 1 + w + s_round && k < 1 + w + s_round + s_len);
      in_ready = (c >= tout + r_delay);
      rst      = (abort_round >= 0 && k == 1 + w + abort_round);
      @(negedge clk);
      if (k == 0) begin
        chk("accept_ld", state_ld, 1);
        chk("accept_ready", out_ready, 1);
      end
      if (k >= 1 && k <= w) begin
        chk("waitkey_en", state_en, 0);
        chk("waitkey_busy", busy, 1);
        chk("waitkey_rk", rk_idx, 0);
      end
      if (s_len > 0 && k >= 1 + w + s_round && k < 1 + w + s_round + s_len) begin
        chk("stall_en", state_en, 0);
        chk("stall_round", round_num, 4'(s_round));
        chk("stall_rk", rk_idx, dec ? 4'(NR - s_round) : 4'(s_round));
      end
      if (k > 0 && noise && c < tout) chk("noise_no_ld", state_ld, 0);
      if (abort_round >= 0 && k == 1 + w + abort_round) begin
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        return;
      end
      if (c == tout + r_delay) begin
        chk("handoff_ready", out_ready, 0);
        chk("handoff_busy", busy, 1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_dec = 0; key_rdy = 1; in_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;

    run_block(0, 0, 0, 0, 0, 0, -1);  idle(2);   // plain encrypt
    run_block(1, 0, 0, 0, 0, 0, -1);  idle(2);   // plain decrypt
    run_block(0, 3, 5, 2, 0, 0, -1);  idle(2);   // key waits, valid at T+17
    run_block(0, 0, 0, 0, 4, 1, -1);             // ready backpressure, noise
    run_block(1, 0, 0, 0, 0, 1, -1);  idle(2);   // back-to-back decrypt, fDec toggling
    run_block(1, 0, 0, 0, 0, 0, 6);              // reset at round 6

    @(negedge clk);
    check_reset("abort");
    chk("abort_sb_flushed", sb.size(), 0);
    @(posedge clk); #1;
    run_block(0, 0, 0, 0, 0, 0, -1);  idle(3);   // recovery encrypt

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("load_count", ld_count, 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
